// File: rtl/pong_pkg.sv
// Shared types and constants for the PONG score/rally sequencer.
// Holds the game state encoding, BCD digit width, serve directions and a BCD increment helper.
package pong_pkg;

  localparam int DIGIT_W = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PAUSE     = 3'd1,
    S_SERVE     = 3'd2,
    S_PLAY      = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  // Two-digit packed BCD {tens, units} plus one; 99 wraps to 00.
  function automatic logic [2*DIGIT_W-1:0] bcd_inc2(input logic [2*DIGIT_W-1:0] v);
    logic [DIGIT_W-1:0] u;
    logic [DIGIT_W-1:0] t;
    u = v[DIGIT_W-1:0];
    t = v[2*DIGIT_W-1:DIGIT_W];
    if (u == DIGIT_W'(9)) begin
      u = '0;
      t = (t == DIGIT_W'(9)) ? '0 : t + DIGIT_W'(1);
    end else begin
      u = u + DIGIT_W'(1);
    end
    return {t, u};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two cascaded BCD digits for one player's score; clr is synchronous and wins over inc.
// Latency: digits update on the edge that samples inc; no backpressure (pulse input).
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q0,
  output logic [DIGIT_W-1:0] q1
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q0 <= '0;
      q1 <= '0;
    end else if (inc) begin
      if (q0 == DIGIT_W'(9)) begin
        q0 <= '0;
        q1 <= (q1 == DIGIT_W'(9)) ? '0 : q1 + DIGIT_W'(1);
      end else begin
        q0 <= q0 + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_score_controller.sv
// Game sequencer: owns both BCD scores, counts the inter-point pause and issues serve pulses.
// Latency: all outputs registered, one edge after the input event; no backpressure (pulse inputs).
module pong_score_controller
  import pong_pkg::*;
#(
  parameter logic [2*DIGIT_W-1:0] WIN_SCORE    = 8'h11,
  parameter int                   PAUSE_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               point_l,
  input  logic               point_r,
  input  logic               new_game,
  output logic [DIGIT_W-1:0] l_q0,
  output logic [DIGIT_W-1:0] l_q1,
  output logic [DIGIT_W-1:0] r_q0,
  output logic [DIGIT_W-1:0] r_q1,
  output logic               serve,
  output logic               serve_dir,
  output logic               in_play,
  output logic               game_over,
  output logic               winner
);

  localparam int               CNT_W      = $clog2(PAUSE_CYCLES + 1);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dir_nxt;
  logic             winner_nxt;

  logic             ev_l;
  logic             ev_r;
  logic             ev_void;
  logic             score_clr;
  logic             l_win;
  logic             r_win;

  // A simultaneous pair voids the rally; new_game pre-empts any point in the same cycle.
  assign ev_l      = (state == S_PLAY) && point_l && !point_r && !new_game;
  assign ev_r      = (state == S_PLAY) && point_r && !point_l && !new_game;
  assign ev_void   = (state == S_PLAY) && point_l &&  point_r && !new_game;
  assign score_clr = clr | new_game;

  assign l_win = (bcd_inc2({l_q1, l_q0}) == WIN_SCORE);
  assign r_win = (bcd_inc2({r_q1, r_q0}) == WIN_SCORE);

  bcd_score_counter u_left (
    .clk (clk),
    .clr (score_clr),
    .inc (ev_l),
    .q0  (l_q0),
    .q1  (l_q1)
  );

  bcd_score_counter u_right (
    .clk (clk),
    .clr (score_clr),
    .inc (ev_r),
    .q0  (r_q0),
    .q1  (r_q1)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dir_nxt    = serve_dir;
    winner_nxt = winner;
    if (new_game) begin
      state_nxt  = S_PAUSE;
      cnt_nxt    = PAUSE_LOAD;
      dir_nxt    = DIR_LEFT;
      winner_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          if (cnt == '0) begin
            state_nxt = S_SERVE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_SERVE: begin
          state_nxt = S_PLAY;
        end
        S_PLAY: begin
          if (ev_void) begin
            state_nxt = S_PAUSE;
            cnt_nxt   = PAUSE_LOAD;
          end else if (ev_l) begin
            if (l_win) begin
              state_nxt  = S_GAME_OVER;
              winner_nxt = DIR_LEFT;
            end else begin
              state_nxt = S_PAUSE;
              cnt_nxt   = PAUSE_LOAD;
              dir_nxt   = DIR_LEFT;
            end
          end else if (ev_r) begin
            if (r_win) begin
              state_nxt  = S_GAME_OVER;
              winner_nxt = DIR_RIGHT;
            end else begin
              state_nxt = S_PAUSE;
              cnt_nxt   = PAUSE_LOAD;
              dir_nxt   = DIR_RIGHT;
            end
          end
        end
        S_GAME_OVER: begin
          state_nxt = S_GAME_OVER;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they are true flops, aligned with state.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_IDLE;
      cnt       <= '0;
      serve_dir <= DIR_LEFT;
      winner    <= 1'b0;
      serve     <= 1'b0;
      in_play   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      serve_dir <= dir_nxt;
      winner    <= winner_nxt;
      serve     <= (state_nxt == S_SERVE);
      in_play   <= (state_nxt == S_PLAY);
      game_over <= (state_nxt == S_GAME_OVER);
    end
  end

  a_serve_single: assert property (@(posedge clk) disable iff (clr) serve |=> !serve);

endmodule

// File: doc/pong_score_controller.md
# pong_score_controller

Score and rally sequencer for the PONG game. It owns the two 2-digit BCD score counters (left and right player) and accepts point pulses from the ball/collision logic. It runs a game state machine (idle, rally, post-point pause, serve, game over) and drives the serve pulse and score digits that the ball engine and 7-segment/score renderer consume.

## Interface
- `WIN_SCORE`, default 8'h11: winning score, packed BCD {tens, units}; legal range 8'h01..8'h99, both nibbles ≤ 9.
- `PAUSE_CYCLES`, default 50_000_000: clk cycles between a point (or new game) and the next serve; must be ≥ 1.
- `clk` input 1: system clock; all logic is on its rising edge.
- `clr` input 1: reset, synchronous, active-high.
- `point_l` input 1: one-cycle pulse; the left player scored.
- `point_r` input 1: one-cycle pulse; the right player scored.
- `new_game` input 1: one-cycle pulse; clear the scores and start a game.
- `l_q0`, `l_q1` output 4 each: left score units and tens (BCD).
- `r_q0`, `r_q1` output 4 each: right score units and tens (BCD).
- `serve` output 1: one-cycle pulse that launches the ball.
- `serve_dir` output 1: direction for the serve: 0 = toward left, 1 = toward right. Valid whenever `serve` = 1.
- `in_play` output 1: high while the ball is live (PLAY state).
- `game_over` output 1: high in GAME_OVER state.
- `winner` output 1: 0 = left, 1 = right. Valid while `game_over` = 1.

## Operation
- States:
  - IDLE: after reset.
  - PAUSE: counting down to a serve.
  - SERVE: lasts one cycle.
  - PLAY: ball is live.
  - GAME_OVER: a player has reached `WIN_SCORE`.
- Reset (`clr` = 1):
  - State goes to IDLE and all scores to 0.
  - `serve` = 0, `serve_dir` = 0, `in_play` = 0, `game_over` = 0, `winner` = 0.
  - Pause counter goes to 0.
  - Reset overrides every other input in the same cycle.
- IDLE: `new_game` → PAUSE. The pause counter is loaded with `PAUSE_CYCLES - 1`, and `serve_dir` is set to 0.
- PAUSE: the counter decrements each cycle. At 0 the state goes to SERVE.
- SERVE: `serve` = 1 for exactly this one cycle, then the state goes to PLAY.
- PLAY, only `point_l` = 1:
  - Left score increments in BCD: units wrap 9 → 0 with a carry into tens.
  - If the new score equals `WIN_SCORE`, go to GAME_OVER with `winner` = 0.
  - Otherwise go to PAUSE with `serve_dir` = 0 (serve toward the player who conceded is not used; the serve goes toward the scorer's side).
- PLAY, only `point_r` = 1: mirror of the `point_l` case, with `winner` = 1 and `serve_dir` = 1.
- PLAY, `point_l` and `point_r` in the same cycle:
  - The rally is void. Neither score changes.
  - Go to PAUSE; `serve_dir` keeps its previous value.
- Point pulses outside PLAY are ignored, including in SERVE, PAUSE and GAME_OVER.
- `new_game` in any non-reset state:
  - Both scores clear to 0 and `game_over` clears.
  - Go to PAUSE with `serve_dir` = 0; the counter is reloaded.
  - `new_game` takes priority over a simultaneous point pulse.
- GAME_OVER holds the scores until `new_game` or `clr` arrives.
- Scores never exceed `WIN_SCORE`, so no 99 → 00 wrap can occur in legal configurations.

## Timing
- Point pulse in cycle N:
  - Score digits update at the N+1 edge.
  - `in_play` falls at N+1.
  - `game_over`/`winner` are valid at N+1 when the win condition is met.
- `new_game` in cycle N: scores are 0 at N+1. `serve` is high in cycle N+1+`PAUSE_CYCLES`.
- Point at N (non-winning): `serve` is high in cycle N+1+`PAUSE_CYCLES`. `in_play` rises the cycle after.
- `serve` is never high on two consecutive cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `pong_pkg`:
  - State enumeration constants.
  - BCD digit width (4).
  - Direction encodings (`DIR_LEFT` = 0, `DIR_RIGHT` = 1).
- Sub-module `bcd_score_counter`, instantiated twice (left and right):
  - Ports: `clk`, `clr` (sync clear), `inc`, `q0`, `q1`.
  - Two cascaded BCD digits.
  - The controller drives `clr` as (top `clr` | game clear) and `inc` from the decoded point events.
- Win detect: compare {q1, q0} against `WIN_SCORE` on the incremented value.
- Pause counter width: $clog2(`PAUSE_CYCLES`+1).

## Test plan
Benches use `PAUSE_CYCLES` = 4 and `WIN_SCORE` = 8'h11.
- Reset: hold `clr` for 2 cycles, then pulse `new_game` → `serve` is high exactly 5 cycles after the `new_game` cycle with `serve_dir` = 0; `in_play` = 1 the next cycle; all digits are 0.
- BCD carry: give left 10 points, each after a serve → `l_q1`/`l_q0` read 1/0, `r_q1`/`r_q0` read 0/0; each serve follows its point by 5 cycles with `serve_dir` = 0.
- Win: left at 10, `point_l` → `l_q1`/`l_q0` = 1/1, `game_over` = 1 and `winner` = 0 next cycle; further `point_l`/`point_r` pulses leave the scores unchanged and no `serve` occurs.
- Simultaneous: in PLAY, `point_l` = `point_r` = 1 in one cycle → scores unchanged, `serve_dir` unchanged, `serve` after 5 cycles. A pulse during PAUSE → ignored.
- Restart: `new_game` in GAME_OVER or mid-PAUSE, also with a concurrent `point_r` → all digits 0, `game_over` = 0, the pause restarts from the full count.
- Reset mid-pause: assert `clr` 2 cycles after a point → IDLE, no `serve` ever issues, all outputs 0 until the next `new_game`.
